serial_adder_subtractor: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor that processes `DIGIT` bits per clock, LSB digit first, under a start/done handshake. It generalises the 4-bit combinational ripple adder/subtractor to arbitrary `WIDTH`, trading latency for area. It adds registered results, busy/done status and an optional signed-overflow flag. It sits in the datapath wherever a narrow, shared arithmetic unit is acceptable.

---
 rtl/serial_addsub_pkg.sv | 27 ++
 rtl/serial_adder_subtractor_digit_adder.sv | 27 ++
 rtl/serial_adder_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_adder_subtractor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Operation encoding on the op input
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Result-field reset values
   localparam logic RES_FLAG_RESET = 1'b0;

   // Number of digit cycles per operation
   function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Digit counter width; at least one bit so N=1 still has a legal counter
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_subtractor_digit_adder.sv
// DIGIT-bit combinational ripple adder; also exposes the carry into its top bit.
module digit_adder #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             ctop
);

   // Ripple the carry through each bit position
   always_comb begin
      logic c;
      c    = cin;
      sum  = '0;
      ctop = 1'b0;
      for (int i = 0; i < int'(DIGIT); i++) begin
         if (i == int'(DIGIT) - 1) ctop = c;
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor with start/done handshake.
// Signed overflow flag is built only when SERIAL_ADDSUB_OVERFLOW_EN is defined;
// otherwise ovf is tied low.
module serial_adder_subtractor
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = num_digits(WIDTH, DIGIT);
   localparam int unsigned CNT_W = cnt_width(N);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               cout_q, cout_d;

   logic [DIGIT-1:0]   dig_sum;
   logic               dig_cout;
   logic [WIDTH-1:0]   res_shift;
   logic               last_digit;

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
   logic               dig_ctop;
   logic               ovf_q, ovf_d;
`else
   logic               dig_ctop_unused;
`endif

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .x    (a_q[DIGIT-1:0]),
      .y    (b_q[DIGIT-1:0]),
      .cin  (carry_q),
      .sum  (dig_sum),
      .cout (dig_cout),
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      .ctop (dig_ctop)
`else
      .ctop (dig_ctop_unused)
`endif
   );

   // New sum digit enters at the top; works for N=1 where res_q is fully replaced
   assign res_shift  = WIDTH'({dig_sum, res_q} >> DIGIT);
   assign last_digit = (cnt_q == CNT_W'(N - 1));

   // Next-state, datapath shifting and completion loading
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               // Subtract is a + ~b + 1: invert b here, inject the +1 as carry-in
               a_d     = a;
               b_d     = b ^ {WIDTH{op == OP_SUB}};
               carry_d = (op == OP_SUB);
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = dig_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_digit) begin
               s_d     = res_shift;
               cout_d  = dig_cout;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
               ovf_d   = dig_ctop ^ dig_cout;
`endif
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= RES_FLAG_RESET;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
   // Overflow flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= RES_FLAG_RESET;
      else        ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench: a 16/4 instance and a minimum 4/4 instance share clock and reset.
module tb_serial_adder_subtractor;

   localparam int N16 = 4;
   localparam int N4  = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start16 = 1'b0, op16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] s16;

   logic        start4 = 1'b0, op4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4, cout4, ovf4;
   logic [3:0]  s4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_adder_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
   );

   serial_adder_subtractor #(.WIDTH(4), .DIGIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct {
      bit          wide;
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
      string       name;
   } vec_t;

   vec_t vec[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands' unsigned and signed values
   function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                 input logic top, output logic [15:0] rs, output logic rc,
                                 output logic rv);
      longint m, half, ua, ub, full, sa, sb, r;
      m    = longint'(1) << w;
      half = m / 2;
      ua   = longint'(ta) & (m - 1);
      ub   = longint'(tb_) & (m - 1);
      if (top) begin
         full = ua - ub;
         rc   = (ua >= ub);
      end else begin
         full = ua + ub;
         rc   = (full >= m);
      end
      rs = 16'(full & (m - 1));
      sa = (ua >= half) ? ua - m : ua;
      sb = (ub >= half) ? ub - m : ub;
      r  = top ? sa - sb : sa + sb;
      rv = (r >= half) || (r < -half);
   endfunction

   function automatic logic cur_done(input bit wide);
      return wide ? done16 : done4;
   endfunction
   function automatic logic cur_busy(input bit wide);
      return wide ? busy16 : busy4;
   endfunction
   function automatic logic [15:0] cur_s(input bit wide);
      return wide ? s16 : {12'h000, s4};
   endfunction
   function automatic logic cur_cout(input bit wide);
      return wide ? cout16 : cout4;
   endfunction
   function automatic logic cur_ovf(input bit wide);
      return wide ? ovf16 : ovf4;
   endfunction

   task automatic drive(input bit wide, input logic st, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic top);
      if (wide) begin
         start16 = st; a16 = ta; b16 = tb_; op16 = top;
      end else begin
         start4 = st; a4 = ta[3:0]; b4 = tb_[3:0]; op4 = top;
      end
   endtask

   // One operation: start in the current cycle, check latency, busy span and result.
   // Leaves time in the done cycle unless pulse_chk also checks the following cycle.
   task automatic run_op(input bit wide, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic top, input logic [15:0] es, input logic ec,
                         input logic ev, input bit pulse_chk, input string name);
      int n, cyc, busy_cnt;
      logic ev_m;
      n = wide ? N16 : N4;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ev_m = ev;
`else
      ev_m = 1'b0;
`endif
      drive(wide, 1'b1, ta, tb_, top);
      @(posedge clk); #1;
      // Operands scrambled after capture must not matter
      drive(wide, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      cyc = 1;
      busy_cnt = 0;
      while (!cur_done(wide) && cyc < 40) begin
         if (cur_busy(wide)) busy_cnt++;
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, 64'(cyc), 64'(n + 1));
      check({name, " busy cycles"}, 64'(busy_cnt), 64'(n));
      check({name, " s"}, 64'(cur_s(wide)), 64'(es));
      check({name, " cout"}, 64'(cur_cout(wide)), 64'(ec));
      check({name, " ovf"}, 64'(cur_ovf(wide)), 64'(ev_m));
      if (pulse_chk) begin
         @(posedge clk); #1;
         check({name, " done pulse width"}, 64'(cur_done(wide)), 64'(0));
      end
   endtask

   initial begin
      int dones;
      logic [15:0] s_at_done;
      logic [15:0] rs;
      logic rc, rv, top;
      logic [15:0] ta, tb_;

      vec[0] = '{1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "add 1+1"};
      vec[1] = '{1'b1, 16'h0007, 16'h0004, 1'b1, 16'h0003, 1'b1, 1'b0, "sub 7-4"};
      vec[2] = '{1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub 0-1"};
      vec[3] = '{1'b1, 16'h0004, 16'hFFFC, 1'b1, 16'h0008, 1'b0, 1'b0, "sub 4-FFFC"};
      vec[4] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf 7FFF+1"};
      vec[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf 8000-1"};
      vec[6] = '{1'b1, 16'h0007, 16'h0007, 1'b0, 16'h000E, 1'b0, 1'b0, "no ovf 7+7"};
      vec[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, "add FFFF+FFFF"};
      vec[8] = '{1'b0, 16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, "min 7-7"};

      // Reset state
      #12;
      check("reset busy", 64'(busy16), 64'(0));
      check("reset done", 64'(done16), 64'(0));
      check("reset s", 64'(s16), 64'(0));
      check("reset cout", 64'(cout16), 64'(0));
      check("reset ovf", 64'(ovf16), 64'(0));
      check("reset s4/done4", 64'({s4, done4, busy4}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed table
      foreach (vec[i])
         run_op(vec[i].wide, vec[i].a, vec[i].b, vec[i].op, vec[i].s, vec[i].cout, vec[i].ovf,
                1'b1, vec[i].name);

      // Randomised against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ta = 16'($urandom); tb_ = 16'($urandom); top = 1'($urandom);
         model(16, ta, tb_, top, rs, rc, rv);
         run_op(1'b1, ta, tb_, top, rs, rc, rv, 1'b0, "rand16");
         @(posedge clk); #1;
      end
      for (int i = 0; i < 15; i++) begin
         ta = 16'($urandom_range(15)); tb_ = 16'($urandom_range(15)); top = 1'($urandom);
         model(4, ta, tb_, top, rs, rc, rv);
         run_op(1'b0, ta, tb_, top, rs, rc, rv, 1'b0, "rand4");
         @(posedge clk); #1;
      end

      // Back-to-back: second start issued in the done cycle of the first
      run_op(1'b1, 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, "b2b first");
      run_op(1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, "b2b second");

      // Start during RUN is ignored; operand inputs wiggle every cycle
      drive(1'b1, 1'b1, 16'h1234, 16'h0001, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      dones = 0;
      s_at_done = '0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
         if (done16) begin
            dones++;
            s_at_done = s16;
         end
         @(posedge clk); #1;
      end
      check("ignored start done count", 64'(dones), 64'(1));
      check("ignored start s", 64'(s_at_done), 64'(16'h1235));

      // Reset mid-run: asserted in cycle 3
      drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid-run reset s", 64'(s16), 64'(0));
      check("mid-run reset cout/ovf", 64'({cout16, ovf16}), 64'(0));
      check("mid-run reset busy/done", 64'({busy16, done16}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (done16 || busy16) dones++;
         @(posedge clk); #1;
      end
      check("no activity after abort", 64'(dones), 64'(0));
      run_op(1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, "post-reset 2+3");

      // Result holds through idle
      repeat (3) @(posedge clk);
      #1;
      check("s holds in idle", 64'(s16), 64'(16'h0005));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
